// File: rtl/wbs_mem_pkg.sv
// wbs_mem_pkg: shared types and constants for the Wishbone SRAM/CSR controller.
//   region_e    - address-map region selected by adr[19:16]
//   state_e     - transaction sequencer states
//   wb_req_t    - request fields held for the life of a multi-cycle access
//   CSR_*       - CSR byte offsets within region 0
//   region_csb  - active-low chip-select pattern for a memory region
package wbs_mem_pkg;

    localparam logic [31:0] BASE_ADDR_DEF = 32'h3000_0000;
    localparam logic [31:0] ADDR_MASK_DEF = 32'hFFF0_0000;

    localparam int unsigned CSR_OFF_W = 8;
    localparam int unsigned CSB_W     = 4;

    typedef enum logic [2:0] {
        REG_CSR   = 3'd0,
        REG_QUERY = 3'd1,
        REG_LEAF  = 3'd2,
        REG_BEST  = 3'd3,
        REG_NODE  = 3'd4
    } region_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MEM_WR  = 3'd1,
        ST_MEM_RD  = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_ACK     = 3'd4
    } state_e;

    typedef struct packed {
        region_e region;
        logic    half;
    } wb_req_t;

    localparam logic [CSR_OFF_W-1:0] CSR_MODE   = 8'h00;
    localparam logic [CSR_OFF_W-1:0] CSR_DEBUG  = 8'h04;
    localparam logic [CSR_OFF_W-1:0] CSR_DONE   = 8'h08;
    localparam logic [CSR_OFF_W-1:0] CSR_START  = 8'h0C;
    localparam logic [CSR_OFF_W-1:0] CSR_STATUS = 8'h10;

    // Chip-select bit order: [0] query, [1] leaf, [2] best, [3] node.
    function automatic logic [CSB_W-1:0] region_csb(input region_e r);
        case (r)
            REG_QUERY: return 4'b1110;
            REG_LEAF:  return 4'b1101;
            REG_BEST:  return 4'b1011;
            REG_NODE:  return 4'b0111;
            default:   return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/wbs_addr_decode.sv
// wbs_addr_decode: combinational decode of a Wishbone address.
//   adr       in  32      bus address
//   hit_c     out 1       address falls inside the user window
//   mapped_c  out 1       region field selects CSR/query/leaf/best/node
//   region_c  out enum    decoded region (REG_CSR when unmapped)
//   entry_c   out MEM_AW  64-bit SRAM word index
//   half_c    out 1       0 = bits 31:0, 1 = bits 63:32
//   csr_off_c out 8       CSR byte offset
module wbs_addr_decode
    import wbs_mem_pkg::*;
#(
    parameter int unsigned MEM_AW    = 9,
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
    parameter logic [31:0] ADDR_MASK = ADDR_MASK_DEF
) (
    input  logic [31:0]           adr,
    output logic                  hit_c,
    output logic                  mapped_c,
    output region_e               region_c,
    output logic [MEM_AW-1:0]     entry_c,
    output logic                  half_c,
    output logic [CSR_OFF_W-1:0]  csr_off_c
);

    logic [3:0] region_raw;

    assign region_raw = adr[19:16];
    assign hit_c      = ((adr & ADDR_MASK) == BASE_ADDR);
    assign mapped_c   = (region_raw <= 4'd4);
    assign region_c   = mapped_c ? region_e'(region_raw[2:0]) : REG_CSR;
    assign entry_c    = adr[MEM_AW+2:3];
    assign half_c     = adr[2];
    assign csr_off_c  = adr[7:0];

endmodule

// File: rtl/wbs_mem_ctrl.sv
// wbs_mem_ctrl: Wishbone slave bridging the management bus to the accelerator
// SRAMs (query, leaf, best, node) and its control/status registers.
//   Wishbone : wb_clk_i, wb_rst_i (sync, active-high), wbs_stb_i, wbs_cyc_i,
//              wbs_we_i, wbs_sel_i (ignored), wbs_adr_i, wbs_dat_i,
//              wbs_ack_o, wbs_dat_o
//   SRAM     : mem_csb[3:0] (query/leaf/best/node, active-low), mem_web,
//              mem_addr, mem_wdata, {query,leaf,best,node}_rdata
//   Engine   : fsm_busy, fsm_done, fsm_start, mode, debug, host_owns_mem
// Optional: define WBS_RDCACHE_EN to keep the last read word so a following
// upper-half read of the same entry is answered without an SRAM access.
module wbs_mem_ctrl
    import wbs_mem_pkg::*;
#(
    parameter int unsigned MEM_AW    = 9,
    parameter int unsigned RD_LAT    = 1,
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
    parameter logic [31:0] ADDR_MASK = ADDR_MASK_DEF
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic [3:0]        mem_csb,
    output logic              mem_web,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    input  logic [63:0]       query_rdata,
    input  logic [63:0]       leaf_rdata,
    input  logic [63:0]       best_rdata,
    input  logic [63:0]       node_rdata,
    input  logic              fsm_busy,
    input  logic              fsm_done,
    output logic              fsm_start,
    output logic              mode,
    output logic              debug,
    output logic              host_owns_mem
);

    localparam int unsigned CNT_W = 2;

    logic                 hit_c, mapped_c, half_c;
    region_e              region_c;
    logic [MEM_AW-1:0]    entry_c;
    logic [CSR_OFF_W-1:0] csr_off_c;

    wbs_addr_decode #(
        .MEM_AW    (MEM_AW),
        .BASE_ADDR (BASE_ADDR),
        .ADDR_MASK (ADDR_MASK)
    ) u_decode (
        .adr       (wbs_adr_i),
        .hit_c     (hit_c),
        .mapped_c  (mapped_c),
        .region_c  (region_c),
        .entry_c   (entry_c),
        .half_c    (half_c),
        .csr_off_c (csr_off_c)
    );

    state_e            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    wb_req_t           req_q, req_d;
    logic              err, err_d;
    logic [31:0]       staging, staging_d;
    logic              ack_d, web_d, start_d, mode_d, debug_d, host_d, hold_c;
    logic [31:0]       dat_d;
    logic [3:0]        csb_d;
    logic [MEM_AW-1:0] addr_d;
    logic [63:0]       wdata_d;
    logic [63:0]       rd_word_c;
    logic              mem_wr_accept_c, cache_fill_c, cache_hit_c;
    logic [31:0]       cache_rd_c;

    // Read-data mux for the region of the access in flight.
    always_comb begin
        rd_word_c = '0;
        case (req_q.region)
            REG_QUERY: rd_word_c = query_rdata;
            REG_LEAF:  rd_word_c = leaf_rdata;
            REG_BEST:  rd_word_c = best_rdata;
            REG_NODE:  rd_word_c = node_rdata;
            default:   rd_word_c = '0;
        endcase
    end

`ifdef WBS_RDCACHE_EN
    logic              cache_vld;
    region_e           cache_region;
    logic [MEM_AW-1:0] cache_entry;
    logic [63:0]       cache_data;

    // Tag is dropped on any write to the tagged entry or whenever the engine is busy.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cache_vld    <= 1'b0;
            cache_region <= REG_CSR;
            cache_entry  <= '0;
            cache_data   <= '0;
        end else if (fsm_busy ||
                     (mem_wr_accept_c && region_c == cache_region && entry_c == cache_entry)) begin
            cache_vld <= 1'b0;
        end else if (cache_fill_c) begin
            cache_vld    <= 1'b1;
            cache_region <= req_q.region;
            cache_entry  <= mem_addr;
            cache_data   <= rd_word_c;
        end
    end

    assign cache_hit_c = cache_vld && (region_c == cache_region) && (entry_c == cache_entry);
    assign cache_rd_c  = cache_data[63:32];

    logic unused_bits;
    assign unused_bits = ^{wbs_sel_i};
`else
    assign cache_hit_c = 1'b0;
    assign cache_rd_c  = '0;

    logic unused_bits;
    assign unused_bits = ^{wbs_sel_i, mem_wr_accept_c, cache_fill_c};
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d         = state;
        cnt_d           = cnt;
        req_d           = req_q;
        err_d           = err;
        staging_d       = staging;
        ack_d           = 1'b0;
        dat_d           = wbs_dat_o;
        csb_d           = 4'hF;
        web_d           = 1'b1;
        addr_d          = mem_addr;
        wdata_d         = mem_wdata;
        start_d         = 1'b0;
        mode_d          = mode;
        debug_d         = debug;
        mem_wr_accept_c = 1'b0;
        cache_fill_c    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (wbs_stb_i && wbs_cyc_i) begin
                    // Default path: single-cycle ack with zero data.
                    state_d      = ST_ACK;
                    ack_d        = 1'b1;
                    dat_d        = '0;
                    req_d.region = region_c;
                    req_d.half   = half_c;
                    if (!hit_c || !mapped_c) begin
                        err_d = 1'b1;
                    end else if (region_c == REG_CSR) begin
                        if (wbs_we_i) begin
                            case (csr_off_c)
                                CSR_MODE:   mode_d  = wbs_dat_i[0];
                                CSR_DEBUG:  debug_d = wbs_dat_i[0];
                                CSR_START:  start_d = wbs_dat_i[0] && !fsm_busy;
                                CSR_STATUS: if (wbs_dat_i[1]) err_d = 1'b0;
                                default:    ;
                            endcase
                        end else begin
                            case (csr_off_c)
                                CSR_MODE:   dat_d = {31'b0, mode};
                                CSR_DEBUG:  dat_d = {31'b0, debug};
                                CSR_DONE:   dat_d = {31'b0, fsm_done};
                                CSR_STATUS: dat_d = {30'b0, err, fsm_busy};
                                default:    dat_d = '0;
                            endcase
                        end
                    end else if (fsm_busy) begin
                        // Engine owns the SRAMs: refuse without touching them.
                        err_d = 1'b1;
                    end else if (wbs_we_i) begin
                        mem_wr_accept_c = 1'b1;
                        if (region_c == REG_NODE) begin
                            if (!half_c) begin
                                state_d = ST_MEM_WR;
                                ack_d   = 1'b0;
                                csb_d   = region_csb(region_c);
                                web_d   = 1'b0;
                                addr_d  = entry_c;
                                wdata_d = {32'b0, wbs_dat_i};
                            end
                        end else if (!half_c) begin
                            staging_d = wbs_dat_i;
                        end else begin
                            state_d = ST_MEM_WR;
                            ack_d   = 1'b0;
                            csb_d   = region_csb(region_c);
                            web_d   = 1'b0;
                            addr_d  = entry_c;
                            wdata_d = {wbs_dat_i, staging};
                        end
                    end else begin
                        if (region_c == REG_NODE && half_c) begin
                            dat_d = '0;
                        end else if (half_c && cache_hit_c) begin
                            dat_d = cache_rd_c;
                        end else begin
                            state_d = ST_MEM_RD;
                            ack_d   = 1'b0;
                            csb_d   = region_csb(region_c);
                            addr_d  = entry_c;
                        end
                    end
                end
            end
            ST_MEM_WR: begin
                state_d = ST_ACK;
                ack_d   = 1'b1;
                dat_d   = '0;
            end
            ST_MEM_RD: begin
                state_d = ST_RD_WAIT;
                cnt_d   = '0;
            end
            ST_RD_WAIT: begin
                if (cnt == CNT_W'(RD_LAT - 1)) begin
                    state_d      = ST_ACK;
                    ack_d        = 1'b1;
                    dat_d        = req_q.half ? rd_word_c[63:32] : rd_word_c[31:0];
                    cache_fill_c = 1'b1;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // An SRAM access already under way keeps the host mux until it is back in IDLE.
        hold_c = (state_d inside {ST_MEM_WR, ST_MEM_RD, ST_RD_WAIT}) ||
                 (state inside {ST_MEM_WR, ST_RD_WAIT});
        host_d = hold_c ? 1'b1 : !fsm_busy;
    end

    // State and output registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            req_q         <= '0;
            err           <= 1'b0;
            staging       <= '0;
            wbs_ack_o     <= 1'b0;
            wbs_dat_o     <= '0;
            mem_csb       <= 4'hF;
            mem_web       <= 1'b1;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            fsm_start     <= 1'b0;
            mode          <= 1'b0;
            debug         <= 1'b0;
            host_owns_mem <= 1'b1;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            req_q         <= req_d;
            err           <= err_d;
            staging       <= staging_d;
            wbs_ack_o     <= ack_d;
            wbs_dat_o     <= dat_d;
            mem_csb       <= csb_d;
            mem_web       <= web_d;
            mem_addr      <= addr_d;
            mem_wdata     <= wdata_d;
            fsm_start     <= start_d;
            mode          <= mode_d;
            debug         <= debug_d;
            host_owns_mem <= host_d;
        end
    end

endmodule

// File: tb/tb_wbs_mem_ctrl.sv
// tb_wbs_mem_ctrl: directed bench for wbs_mem_ctrl (default parameters, RD_LAT=1).
module tb_wbs_mem_ctrl;

`ifdef WBS_RDCACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic        wb_clk_i;
    logic        wb_rst_i;
    logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [3:0]  mem_csb;
    logic        mem_web;
    logic [8:0]  mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] query_rdata, leaf_rdata, best_rdata, node_rdata;
    logic        fsm_busy, fsm_done, fsm_start, mode, debug, host_owns_mem;

    wbs_mem_ctrl dut (
        .wb_clk_i      (wb_clk_i),
        .wb_rst_i      (wb_rst_i),
        .wbs_stb_i     (wbs_stb_i),
        .wbs_cyc_i     (wbs_cyc_i),
        .wbs_we_i      (wbs_we_i),
        .wbs_sel_i     (wbs_sel_i),
        .wbs_adr_i     (wbs_adr_i),
        .wbs_dat_i     (wbs_dat_i),
        .wbs_ack_o     (wbs_ack_o),
        .wbs_dat_o     (wbs_dat_o),
        .mem_csb       (mem_csb),
        .mem_web       (mem_web),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .query_rdata   (query_rdata),
        .leaf_rdata    (leaf_rdata),
        .best_rdata    (best_rdata),
        .node_rdata    (node_rdata),
        .fsm_busy      (fsm_busy),
        .fsm_done      (fsm_done),
        .fsm_start     (fsm_start),
        .mode          (mode),
        .debug         (debug),
        .host_owns_mem (host_owns_mem)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    int errors = 0;
    int checks = 0;
    int cyc_cnt = 0;
    int t0 = 0;

    // Bus-side monitor, sampled on the falling edge.
    int          strobes = 0, starts = 0, acks = 0;
    logic [3:0]  last_csb = 4'hF;
    logic [8:0]  last_maddr = '0;
    logic [63:0] last_wdata = '0;
    logic        last_web = 1'b1;
    logic        ack_host = 1'b0;

    always @(posedge wb_clk_i) cyc_cnt++;

    always @(negedge wb_clk_i) begin
        if (mem_csb != 4'hF) begin
            strobes++;
            last_csb   = mem_csb;
            last_maddr = mem_addr;
            last_wdata = mem_wdata;
            last_web   = mem_web;
        end
        if (fsm_start) starts++;
        if (wbs_ack_o) begin
            acks++;
            ack_host = host_owns_mem;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    // Called #1 after a rising edge; the request is seen on the next edge.
    task automatic wb_issue(input logic we, input logic [31:0] adr, input logic [31:0] dat);
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_dat_i = dat;
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        t0        = cyc_cnt;
    endtask

    task automatic wb_wait(input string nm, output logic [31:0] rdata, output int ncyc);
        bit got;
        got   = 1'b0;
        ncyc  = -1;
        rdata = '0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge wb_clk_i); #1;
            if (wbs_ack_o) begin
                got       = 1'b1;
                ncyc      = cyc_cnt - t0;
                rdata     = wbs_dat_o;
                wbs_stb_i = 1'b0;
                wbs_cyc_i = 1'b0;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s: no ack within 20 cycles", nm);
            wbs_stb_i = 1'b0;
            wbs_cyc_i = 1'b0;
        end else begin
            @(posedge wb_clk_i); #1;
            chk({nm, "_ack_width"}, 64'(wbs_ack_o), 64'd0);
        end
    endtask

    task automatic wb_xfer(input string nm, input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, output logic [31:0] rdata, output int ncyc);
        wb_issue(we, adr, dat);
        wb_wait(nm, rdata, ncyc);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [31:0] exp_dat;
        int          exp_cyc;
        int          exp_strb;
        logic [3:0]  exp_csb;
        logic [8:0]  exp_maddr;
        logic [63:0] exp_wdata;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs[NV];

    initial begin
        logic [31:0] rd;
        int          n, s0, a0, st0;

        vecs[0]  = '{1'b1, 32'h3002_0028, 32'h0000_1234, 32'h0, 1, 0, 4'hF, 9'd0, 64'h0};
        vecs[1]  = '{1'b1, 32'h3002_002C, 32'h0ABC_0001, 32'h0, 2, 1, 4'b1101, 9'd5, 64'h0ABC_0001_0000_1234};
        vecs[2]  = '{1'b0, 32'h3003_0038, 32'h0, 32'h0000_07FF, 3, 1, 4'b1011, 9'd7, 64'h0};
        vecs[3]  = '{1'b0, 32'h3003_003C, 32'h0, 32'hDEAD_BEEF, CACHE ? 1 : 3, CACHE ? 0 : 1, 4'b1011, 9'd7, 64'h0};
        vecs[4]  = '{1'b1, 32'h3000_0000, 32'h1, 32'h0, 1, 0, 4'hF, 9'd0, 64'h0};
        vecs[5]  = '{1'b0, 32'h3000_0000, 32'h0, 32'h1, 1, 0, 4'hF, 9'd0, 64'h0};
        vecs[6]  = '{1'b1, 32'h3000_0004, 32'h1, 32'h0, 1, 0, 4'hF, 9'd0, 64'h0};
        vecs[7]  = '{1'b0, 32'h3000_0004, 32'h0, 32'h1, 1, 0, 4'hF, 9'd0, 64'h0};
        vecs[8]  = '{1'b0, 32'h3000_0008, 32'h0, 32'h1, 1, 0, 4'hF, 9'd0, 64'h0};
        vecs[9]  = '{1'b1, 32'h3004_0010, 32'hCAFE_0042, 32'h0, 2, 1, 4'b0111, 9'd2, 64'h0000_0000_CAFE_0042};
        vecs[10] = '{1'b0, 32'h3004_0014, 32'h0, 32'h0, 1, 0, 4'hF, 9'd0, 64'h0};
        vecs[11] = '{1'b0, 32'h3004_0010, 32'h0, 32'h3333_4444, 3, 1, 4'b0111, 9'd2, 64'h0};
        vecs[12] = '{1'b1, 32'h3001_000C, 32'h5555_AAAA, 32'h0, 2, 1, 4'b1110, 9'd1, 64'h5555_AAAA_0000_1234};
        vecs[13] = '{1'b0, 32'h3000_0010, 32'h0, 32'h0, 1, 0, 4'hF, 9'd0, 64'h0};
        vecs[14] = '{1'b0, 32'h4000_0000, 32'h0, 32'h0, 1, 0, 4'hF, 9'd0, 64'h0};
        vecs[15] = '{1'b0, 32'h3000_0010, 32'h0, 32'h2, 1, 0, 4'hF, 9'd0, 64'h0};
        vecs[16] = '{1'b1, 32'h3000_0010, 32'h2, 32'h0, 1, 0, 4'hF, 9'd0, 64'h0};
        vecs[17] = '{1'b0, 32'h3000_0010, 32'h0, 32'h0, 1, 0, 4'hF, 9'd0, 64'h0};
        vecs[18] = '{1'b0, 32'h3005_0000, 32'h0, 32'h0, 1, 0, 4'hF, 9'd0, 64'h0};
        vecs[19] = '{1'b0, 32'h3000_0010, 32'h0, 32'h2, 1, 0, 4'hF, 9'd0, 64'h0};
        vecs[20] = '{1'b1, 32'h3000_0010, 32'h2, 32'h0, 1, 0, 4'hF, 9'd0, 64'h0};
        vecs[21] = '{1'b0, 32'h3000_0010, 32'h0, 32'h0, 1, 0, 4'hF, 9'd0, 64'h0};

        wb_rst_i    = 1'b1;
        wbs_stb_i   = 1'b0;
        wbs_cyc_i   = 1'b0;
        wbs_we_i    = 1'b0;
        wbs_sel_i   = 4'hF;
        wbs_adr_i   = '0;
        wbs_dat_i   = '0;
        fsm_busy    = 1'b0;
        fsm_done    = 1'b1;
        query_rdata = 64'h5A5A_5A5A_A5A5_A5A5;
        leaf_rdata  = 64'h0123_4567_89AB_CDEF;
        best_rdata  = 64'hDEAD_BEEF_0000_07FF;
        node_rdata  = 64'h1111_2222_3333_4444;

        repeat (3) @(posedge wb_clk_i);
        #1;
        chk("rst_ack",   64'(wbs_ack_o), 64'd0);
        chk("rst_dat",   64'(wbs_dat_o), 64'd0);
        chk("rst_csb",   64'(mem_csb), 64'hF);
        chk("rst_web",   64'(mem_web), 64'd1);
        chk("rst_addr",  64'(mem_addr), 64'd0);
        chk("rst_wdata", mem_wdata, 64'd0);
        chk("rst_start", 64'(fsm_start), 64'd0);
        chk("rst_mode",  64'(mode), 64'd0);
        chk("rst_debug", 64'(debug), 64'd0);
        chk("rst_host",  64'(host_owns_mem), 64'd1);
        wb_rst_i = 1'b0;
        @(posedge wb_clk_i); #1;

        // Directed vector table.
        for (int i = 0; i < NV; i++) begin
            s0 = strobes;
            wb_xfer($sformatf("vec%0d", i), vecs[i].we, vecs[i].adr, vecs[i].dat, rd, n);
            chk($sformatf("vec%0d_cyc", i), 64'(n), 64'(vecs[i].exp_cyc));
            chk($sformatf("vec%0d_strobes", i), 64'(strobes - s0), 64'(vecs[i].exp_strb));
            if (!vecs[i].we)
                chk($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_dat));
            if (vecs[i].exp_strb > 0) begin
                chk($sformatf("vec%0d_csb", i), 64'(last_csb), 64'(vecs[i].exp_csb));
                chk($sformatf("vec%0d_maddr", i), 64'(last_maddr), 64'(vecs[i].exp_maddr));
                chk($sformatf("vec%0d_web", i), 64'(last_web), 64'(!vecs[i].we));
                if (vecs[i].we)
                    chk($sformatf("vec%0d_wdata", i), last_wdata, vecs[i].exp_wdata);
            end
        end

        // Start pulse: exactly one cycle per write of bit0=1.
        st0 = starts;
        wb_xfer("start", 1'b1, 32'h3000_000C, 32'h1, rd, n);
        chk("start_pulse_cycles", 64'(starts - st0), 64'd1);

        // Engine busy: SRAM refused, err set, host loses the mux.
        fsm_busy = 1'b1;
        @(posedge wb_clk_i); #1;
        chk("busy_host", 64'(host_owns_mem), 64'd0);
        s0 = strobes;
        wb_xfer("busy_wr", 1'b1, 32'h3001_0004, 32'h1234_5678, rd, n);
        chk("busy_wr_cyc", 64'(n), 64'd1);
        wb_xfer("busy_rd", 1'b0, 32'h3002_002C, 32'h0, rd, n);
        chk("busy_rd_cyc", 64'(n), 64'd1);
        chk("busy_rd_data", 64'(rd), 64'd0);
        chk("busy_strobes", 64'(strobes - s0), 64'd0);
        wb_xfer("busy_status", 1'b0, 32'h3000_0010, 32'h0, rd, n);
        chk("busy_status_data", 64'(rd), 64'h3);
        st0 = starts;
        wb_xfer("busy_start", 1'b1, 32'h3000_000C, 32'h1, rd, n);
        chk("busy_start_ignored", 64'(starts - st0), 64'd0);
        fsm_busy = 1'b0;
        wb_xfer("err_clr", 1'b1, 32'h3000_0010, 32'h2, rd, n);
        wb_xfer("idle_status", 1'b0, 32'h3000_0010, 32'h0, rd, n);
        chk("idle_status_data", 64'(rd), 64'h0);
        chk("idle_host", 64'(host_owns_mem), 64'd1);

        // Busy rises mid-read: the read completes, host mux held until IDLE.
        s0 = strobes;
        wb_issue(1'b0, 32'h3003_0038, 32'h0);
        @(posedge wb_clk_i); #1;
        fsm_busy = 1'b1;
        wb_wait("inflight", rd, n);
        chk("inflight_cyc", 64'(n), 64'd3);
        chk("inflight_data", 64'(rd), 64'h0000_07FF);
        chk("inflight_strobes", 64'(strobes - s0), 64'd1);
        chk("inflight_host_at_ack", 64'(ack_host), 64'd1);
        chk("inflight_host_after", 64'(host_owns_mem), 64'd0);
        fsm_busy = 1'b0;
        @(posedge wb_clk_i); #1;

        // Strobe dropped early: transaction still completes and acks.
        wb_issue(1'b0, 32'h3003_003C, 32'h0);
        @(posedge wb_clk_i); #1;
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wb_wait("abort", rd, n);
        chk("abort_cyc", 64'(n), 64'd3);
        chk("abort_data", 64'(rd), 64'hDEAD_BEEF);

        // Reset during RD_WAIT: no ack, outputs back to reset values.
        wb_issue(1'b0, 32'h3003_0038, 32'h0);
        @(posedge wb_clk_i); #1;
        @(posedge wb_clk_i); #1;
        a0        = acks;
        wb_rst_i  = 1'b1;
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        @(posedge wb_clk_i); #1;
        chk("midrst_ack",  64'(wbs_ack_o), 64'd0);
        chk("midrst_dat",  64'(wbs_dat_o), 64'd0);
        chk("midrst_csb",  64'(mem_csb), 64'hF);
        chk("midrst_web",  64'(mem_web), 64'd1);
        chk("midrst_addr", 64'(mem_addr), 64'd0);
        chk("midrst_mode", 64'(mode), 64'd0);
        chk("midrst_dbg",  64'(debug), 64'd0);
        chk("midrst_host", 64'(host_owns_mem), 64'd1);
        wb_rst_i = 1'b0;
        repeat (4) @(posedge wb_clk_i);
        #1;
        chk("midrst_no_ack", 64'(acks - a0), 64'd0);

        // Lower then upper half of one leaf entry; cache build serves the upper half.
        s0 = strobes;
        wb_xfer("lf3_lo", 1'b0, 32'h3002_0018, 32'h0, rd, n);
        chk("lf3_lo_cyc", 64'(n), 64'd3);
        chk("lf3_lo_data", 64'(rd), 64'h89AB_CDEF);
        wb_xfer("lf3_hi", 1'b0, 32'h3002_001C, 32'h0, rd, n);
        chk("lf3_hi_cyc", 64'(n), CACHE ? 64'd1 : 64'd3);
        chk("lf3_hi_data", 64'(rd), 64'h0123_4567);
        chk("lf3_strobes", 64'(strobes - s0), CACHE ? 64'd1 : 64'd2);
        // A write to the same entry forces the next upper read back to SRAM.
        wb_xfer("lf3_wr", 1'b1, 32'h3002_0018, 32'h0000_0077, rd, n);
        s0 = strobes;
        wb_xfer("lf3_hi2", 1'b0, 32'h3002_001C, 32'h0, rd, n);
        chk("lf3_hi2_cyc", 64'(n), 64'd3);
        chk("lf3_hi2_strobes", 64'(strobes - s0), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wbs_mem_ctrl.md
Name: wbs_mem_ctrl

Overview:
- Wishbone slave controller between the Caravel management bus and the accelerator's on-chip SRAMs (query, leaf, best-match, internal-node) and its control/status registers.
- Decodes the address map and packs 32-bit bus writes into 64-bit SRAM words.
- Sequences SRAM read/write strobes and generates `wbs_ack_o`.
- Arbitrates SRAM ownership: the search engine owns the SRAMs while it is busy; the host owns them otherwise.

Parameters:
- `MEM_AW`, 9: SRAM word-address width per region.
- `RD_LAT`, 1: SRAM read latency in cycles (1..3).
- `BASE_ADDR`, 32'h3000_0000: base of the user address window.
- `ADDR_MASK`, 32'hFFF0_0000: bits compared against `BASE_ADDR`.

Ports:
- `wb_clk_i` in 1: single clock.
- `wb_rst_i` in 1: reset, synchronous, active-high.
- `wbs_stb_i` in 1, `wbs_cyc_i` in 1, `wbs_we_i` in 1: Wishbone strobe, cycle and write-enable.
- `wbs_sel_i` in 4: byte selects; ignored, full-word accesses only.
- `wbs_adr_i` in 32, `wbs_dat_i` in 32: Wishbone address and write data.
- `wbs_ack_o` out 1, `wbs_dat_o` out 32: Wishbone acknowledge and read data.
- `mem_csb` out 4: active-low chip selects; [0] query, [1] leaf, [2] best, [3] node.
- `mem_web` out 1: active-low write enable, shared by all regions.
- `mem_addr` out MEM_AW, `mem_wdata` out 64: shared SRAM address and write data.
- `query_rdata` in 64, `leaf_rdata` in 64, `best_rdata` in 64, `node_rdata` in 64: per-region SRAM read data.
- `fsm_busy` in 1, `fsm_done` in 1: engine status.
- `fsm_start` out 1: one-cycle start pulse to the engine.
- `mode` out 1, `debug` out 1: configuration register bits.
- `host_owns_mem` out 1: SRAM mux select to the engine; 1 = this block drives the SRAMs.

Behaviour:
- **Reset values:** all outputs 0, except `mem_csb`=4'hF, `mem_web`=1 and `host_owns_mem`=1. Staging register, sticky error bit and FSM clear; FSM goes to IDLE. Reset mid-transaction abandons it with no ack.
- **Address decode:** hit = `((wbs_adr_i & ADDR_MASK) == BASE_ADDR)`. Region = `adr[19:16]`: 0 CSR, 1 query, 2 leaf, 3 best, 4 node; 5..15 unmapped. Entry = `adr[MEM_AW+2:3]`. Half = `adr[2]` (0 = bits 31:0, 1 = bits 63:32).
- **CSR offsets (`adr[7:0]`):**
  - 0x00 mode (RW, bit0).
  - 0x04 debug (RW, bit0).
  - 0x08 done (RO, `fsm_done`).
  - 0x0C start (WO; write of bit0=1 pulses `fsm_start` for exactly one cycle, ignored while `fsm_busy`).
  - 0x10 status (RO: bit0 `fsm_busy`, bit1 sticky err; a write of bit1=1 clears err).
- **FSM states:** IDLE, MEM_WR, MEM_RD, RD_WAIT, ACK.
- **IDLE:** accepts a request when `stb&cyc`. Requests that are not hits, or hit an unmapped region, go to ACK with `wbs_dat_o`=0 and set err.
- **CSR access:** IDLE→ACK. Ack one cycle after the request is seen.
- **Write, half 0** (query/leaf/best): capture into staging[31:0]; IDLE→ACK. No SRAM activity.
- **Write, half 1:** IDLE→MEM_WR. MEM_WR drives its region's csb low and `mem_web`=0 for one cycle, with `mem_wdata`={dat_i, staging[31:0]}; then →ACK. Ack at cycle 2.
- **Node region (32-bit entries):** a half-0 write commits {32'b0, dat_i} directly via MEM_WR. Half-1 writes are acked with no effect; half-1 reads return 0.
- **Read:** IDLE→MEM_RD (csb low, web=1, one cycle) → RD_WAIT for RD_LAT cycles → ACK. The selected half of the region's rdata is registered into `wbs_dat_o`. Ack at cycle RD_LAT+2.
- **ACK:** `wbs_ack_o`=1 for exactly one cycle, then →IDLE. `wbs_dat_o` holds until the next ack.
- **Arbitration:** `host_owns_mem` = !`fsm_busy`, registered.
  - While `fsm_busy`=1, memory-region accesses do not touch the SRAM: writes are dropped, reads return 0, err is set, and ack follows CSR timing.
  - If `fsm_busy` rises while in MEM_WR/MEM_RD/RD_WAIT, the in-flight access completes first; `host_owns_mem` falls only on return to IDLE.
- **Abort:** dropping `stb` before ack is illegal. The block still completes the transaction and acks.

Optional Feature:
- Macro: `WBS_RDCACHE_EN`.
- **Defined:** the last 64-bit read word is kept with its {region, entry} tag. A half-1 read that matches the tag is served from the cache with CSR timing and no SRAM strobe. Any write to the tagged entry, or `fsm_busy` rising, invalidates the tag.
- **Undefined:** every read strobes the SRAM.

Decomposition:
- Package `wbs_mem_pkg`: region enum (CSR, QUERY, LEAF, BEST, NODE), CSR offset constants, FSM state enum, BASE/MASK defaults.
- One natural sub-module: `wbs_addr_decode` (combinational hit/region/entry/half/csr-offset decode).

Test Plan:
- Write leaf entry 5: lower 0x0000_1234, then upper 0x0ABC_0001 → a single SRAM write, `mem_csb`=4'b1101, `mem_addr`=5, `mem_wdata`=64'h0ABC_0001_0000_1234, ack on cycle 2.
- Read best entry 7, halves 0 then 1, with `best_rdata`=64'hDEAD_BEEF_0000_07FF and RD_LAT=1 → `wbs_dat_o`=0x0000_07FF then 0xDEAD_BEEF, each acked at cycle 3.
- Write 1 to CSR 0x0C → `fsm_start` high for exactly one cycle. Drive `fsm_busy`=1, then write to query entry 0 → SRAM untouched, status reads 0x3.
- Read address 0x3005_0000 → ack with `wbs_dat_o`=0 and err set. Write 0x2 to status → err cleared.
- Assert `wb_rst_i` during RD_WAIT → no ack; outputs return to reset values the next cycle.
- With `WBS_RDCACHE_EN`: read leaf entry 3 half 0, then half 1 → only one csb strobe, second ack at cycle 1.
